// File: rtl/risc_multicycle_core.sv
// risc_multicycle_core: multi-cycle 16-bit RISC core with handshaked data memory and an OUT FIFO
module risc_multicycle_core #(
  parameter int LENGTH = 16,
  parameter int IR_DEPTH = 32,
  parameter int REG_FILE_DEPTH = 8,
  parameter int DM_ADDR_W = 8,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic test_normal,
  input  logic ext_IR_we,
  input  logic [$clog2(IR_DEPTH)-1:0] ext_addr,
  input  logic [LENGTH-1:0] ext_data,
  output logic dm_req,
  output logic dm_we,
  output logic [DM_ADDR_W-1:0] dm_addr,
  output logic [LENGTH-1:0] dm_wdata,
  input  logic [LENGTH-1:0] dm_rdata,
  input  logic dm_ack,
  output logic out_valid,
  output logic [LENGTH-1:0] out_data,
  input  logic out_ready,
  input  logic resume,
  output logic done,
  output logic [CNT_W-1:0] retired
);
  localparam int IA = $clog2(IR_DEPTH);
  localparam int SW = $clog2(LENGTH);
  localparam int PW = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [4:0] OP_ADD = 5'd1, OP_SUB = 5'd2, OP_AND = 5'd3, OP_OR = 5'd4, OP_XOR = 5'd5,
                         OP_SHL = 5'd6, OP_SHR = 5'd7, OP_ADDI = 5'd8, OP_LD = 5'd9, OP_ST = 5'd10,
                         OP_BEQ = 5'd11, OP_BNE = 5'd12, OP_BLT = 5'd13, OP_BCS = 5'd14, OP_JMP = 5'd15,
                         OP_JAL = 5'd16, OP_JR = 5'd17, OP_OUT = 5'd18, OP_HLT = 5'd19;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t st, nxt;
  logic [LENGTH-1:0] imem [IR_DEPTH];
  logic [LENGTH-1:0] regs [REG_FILE_DEPTH];
  logic [LENGTH-1:0] fifo [OUT_DEPTH];
  logic [LENGTH-1:0] pc, ir_q, rd0_q, rd1_q, imm_q, alu_q, npc_q, mem_q;
  logic [LENGTH-1:0] opb, bx, alu_r, npc, wb_data;
  logic [LENGTH:0] sum;
  logic [3:0] nzcv;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [4:0] op;
  logic [2:0] rd_f, ra_f, rb_f;
  logic sub, arith, alu_op, mem_op, taken, reg_we, full, pop, stall, wb_go, push, restart;
  assign op = ir_q[LENGTH-1 -: 5];
  assign rd_f = ir_q[10:8];
  assign ra_f = ir_q[7:5];
  assign rb_f = ir_q[4:2];
  assign sub = op == OP_SUB;
  assign arith = op == OP_ADD || sub || op == OP_ADDI;
  assign alu_op = op >= OP_ADD && op <= OP_ADDI;
  assign mem_op = op == OP_LD || op == OP_ST;
  assign opb = (op == OP_ADDI || mem_op) ? imm_q : rd1_q;
  assign bx = sub ? ~opb : opb;
  assign sum = {1'b0, rd0_q} + {1'b0, bx} + {{LENGTH{1'b0}}, sub};
  assign alu_r = op == OP_AND ? rd0_q & opb : op == OP_OR ? rd0_q | opb : op == OP_XOR ? rd0_q ^ opb :
                 op == OP_SHL ? rd0_q << opb[SW-1:0] : op == OP_SHR ? rd0_q >> opb[SW-1:0] : sum[LENGTH-1:0];
  assign taken = (op == OP_BEQ && nzcv[2]) || (op == OP_BNE && !nzcv[2]) ||
                 (op == OP_BLT && (nzcv[3] != nzcv[0])) || (op == OP_BCS && nzcv[1]);
  assign npc = taken ? pc + imm_q : (op == OP_JMP || op == OP_JAL) ? imm_q : op == OP_JR ? rd0_q : pc + LENGTH'(1);
  assign reg_we = alu_op || op == OP_LD || op == OP_JAL;
  assign wb_data = op == OP_LD ? mem_q : op == OP_JAL ? pc : alu_q;
  assign out_valid = cnt != '0;
  assign full = cnt == CW'(OUT_DEPTH);
  assign pop = out_ready && out_valid;
  // A full FIFO holds the OUT in WB unless a pop frees a slot on the same edge
  assign stall = op == OP_OUT && full && !pop;
  assign wb_go = st == WB && !stall && !test_normal;
  assign push = wb_go && op == OP_OUT;
  assign restart = st == HALT && resume && !test_normal;
  assign dm_req = st == MEM;
  assign dm_we = dm_req && op == OP_ST;
  assign dm_addr = alu_q[DM_ADDR_W-1:0];
  assign dm_wdata = rd1_q;
  assign out_data = fifo[rp];
  assign done = st == HALT;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = FETCH;
      FETCH:   nxt = DECODE;
      DECODE:  nxt = EXEC;
      EXEC:    nxt = mem_op ? MEM : op == OP_HLT ? HALT : WB;
      MEM:     nxt = dm_ack ? WB : MEM;
      WB:      nxt = stall ? WB : FETCH;
      HALT:    nxt = resume ? FETCH : HALT;
      default: nxt = IDLE;
    endcase
    if (test_normal) nxt = IDLE;
  end
  always_ff @(posedge clk)
    if (test_normal && ext_IR_we) imem[ext_addr] <= ext_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pc <= '0;
      ir_q <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
      imm_q <= '0;
      alu_q <= '0;
      npc_q <= '0;
      mem_q <= '0;
      nzcv <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      retired <= '0;
      for (int i = 0; i < REG_FILE_DEPTH; i++) regs[i] <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (test_normal) pc <= '0;
      else if (wb_go) pc <= npc_q;
      else if (restart) pc <= pc + LENGTH'(1);
      if (st == FETCH) ir_q <= imem[pc[IA-1:0]];
      if (st == DECODE) begin
        rd0_q <= regs[ra_f];
        rd1_q <= regs[op == OP_ST ? rd_f : rb_f];
        imm_q <= (op == OP_JMP || op == OP_JAL) ? {pc[LENGTH-1:11], ir_q[10:0]} : {{(LENGTH-5){ir_q[4]}}, ir_q[4:0]};
      end
      if (st == EXEC) begin
        alu_q <= alu_r;
        npc_q <= npc;
        if (alu_op) nzcv <= {alu_r[LENGTH-1], alu_r == '0, arith & sum[LENGTH],
                             arith & (rd0_q[LENGTH-1] == bx[LENGTH-1]) & (sum[LENGTH-1] != rd0_q[LENGTH-1])};
      end
      if (dm_req && dm_ack) mem_q <= dm_rdata;
      if (wb_go && reg_we) regs[op == OP_JAL ? 3'd7 : rd_f] <= wb_data;
      if (push) begin
        fifo[wp] <= rd0_q;
        wp <= wp == PW'(OUT_DEPTH - 1) ? '0 : wp + PW'(1);
      end
      if (pop) rp <= rp == PW'(OUT_DEPTH - 1) ? '0 : rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (wb_go || restart) retired <= retired + CNT_W'(1);
    end
endmodule

// File: tb/tb_risc_multicycle_core.sv
// tb_risc_multicycle_core: directed programs with hand-computed results for the multi-cycle core
module tb_risc_multicycle_core;
  localparam logic [4:0] OP_SHL = 5'd6, OP_ADDI = 5'd8, OP_LD = 5'd9, OP_ST = 5'd10, OP_OUT = 5'd18, OP_HLT = 5'd19;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic test_normal = 1'b1;
  logic ext_IR_we = 1'b0;
  logic [4:0] ext_addr = '0;
  logic [15:0] ext_data = '0;
  logic dm_req, dm_we, dm_ack, out_valid, done;
  logic out_ready = 1'b0;
  logic resume = 1'b0;
  logic [7:0] dm_addr;
  logic [15:0] dm_wdata, dm_rdata, out_data;
  logic [31:0] retired;
  int n_tests = 0;
  int n_fail = 0;
  int delay = 0;
  int hold_err = 0;
  int c;
  logic [15:0] dmem [256];
  logic [15:0] prog [$];
  logic [15:0] outs [$];
  int acc_len [$];
  logic [15:0] acc_addr [$];
  logic [15:0] acc_wd [$];
  logic acc_we [$];

  always #5 clk = ~clk;

  risc_multicycle_core dut (
    .clk(clk), .reset_n(reset_n), .test_normal(test_normal), .ext_IR_we(ext_IR_we),
    .ext_addr(ext_addr), .ext_data(ext_data), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .resume(resume), .done(done), .retired(retired)
  );

  function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [4:0] im);
    return {op, rd, ra, im};
  endfunction

  function automatic logic [31:0] qv(input int i);
    return i < outs.size() ? 32'(outs[i]) : 32'hDEAD;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    test_normal = 1'b1;
    ext_IR_we = 1'b0;
    out_ready = 1'b0;
    resume = 1'b0;
    delay = 0;
    step;
    step;
    reset_n = 1'b1;
    outs.delete();
    acc_len.delete();
    acc_addr.delete();
    acc_wd.delete();
    acc_we.delete();
    hold_err = 0;
  endtask

  task automatic load;
    foreach (prog[i]) begin
      ext_addr = 5'(i);
      ext_data = prog[i];
      ext_IR_we = 1'b1;
      step;
    end
    ext_IR_we = 1'b0;
    prog.delete();
  endtask

  task automatic run_until_done(input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      step;
      n++;
    end
    check("done_reached", 32'(done), 1);
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (!dm_req && n < max) begin
      step;
      n++;
    end
    check("req_seen", 32'(dm_req), 1);
  endtask

  // Data memory responder: acks after `delay` extra cycles, records each completed access
  initial begin
    int wcnt;
    logic [15:0] a0, w0;
    logic we0;
    wcnt = 0;
    a0 = '0;
    w0 = '0;
    we0 = 1'b0;
    dm_ack = 1'b0;
    dm_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (dm_req) begin
        if (wcnt == 0) begin
          a0 = 16'(dm_addr);
          w0 = dm_wdata;
          we0 = dm_we;
        end else if (16'(dm_addr) != a0 || dm_wdata != w0 || dm_we != we0) hold_err++;
        wcnt++;
        dm_ack = wcnt > delay;
        if (dm_ack) begin
          dm_rdata = dmem[dm_addr];
          if (dm_we) dmem[dm_addr] = dm_wdata;
          acc_len.push_back(wcnt);
          acc_addr.push_back(a0);
          acc_wd.push_back(w0);
          acc_we.push_back(we0);
        end
      end else begin
        wcnt = 0;
        dm_ack = delay == 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (out_valid && out_ready) outs.push_back(out_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    step;
    check("rst_dm_req", 32'(dm_req), 0);
    check("rst_dm_we", 32'(dm_we), 0);
    check("rst_dm_addr", 32'(dm_addr), 0);
    check("rst_dm_wdata", 32'(dm_wdata), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_retired", retired, 0);

    // ADDI/OUT/HLT with ack tied high
    do_reset;
    prog = '{ri(OP_ADDI, 1, 0, 5), ri(OP_OUT, 0, 1, 0), ri(OP_HLT, 0, 0, 0)};
    load;
    out_ready = 1'b1;
    test_normal = 1'b0;
    run_until_done(40, c);
    check("t1_done_cycle", c, 12);
    check("t1_out_count", outs.size(), 1);
    check("t1_out_value", qv(0), 5);
    check("t1_out_valid_low", 32'(out_valid), 0);
    check("t1_retired", retired, 2);

    // Build 0x1234 in R2, store then load with 3 wait states each
    do_reset;
    delay = 3;
    prog = '{ri(OP_ADDI, 4, 0, 4), ri(OP_ADDI, 2, 0, 1), ri(OP_SHL, 2, 2, 5'b10000), ri(OP_ADDI, 2, 2, 2),
             ri(OP_SHL, 2, 2, 5'b10000), ri(OP_ADDI, 2, 2, 3), ri(OP_SHL, 2, 2, 5'b10000), ri(OP_ADDI, 2, 2, 4),
             ri(OP_ST, 2, 0, 3), ri(OP_LD, 3, 0, 3), ri(OP_OUT, 0, 3, 0), ri(OP_HLT, 0, 0, 0)};
    load;
    out_ready = 1'b1;
    test_normal = 1'b0;
    run_until_done(200, c);
    check("t2_done_cycle", c, 56);
    check("t2_accesses", acc_len.size(), 2);
    check("t2_st_req_len", acc_len.size() > 0 ? acc_len[0] : -1, 4);
    check("t2_ld_req_len", acc_len.size() > 1 ? acc_len[1] : -1, 4);
    check("t2_st_addr", acc_addr.size() > 0 ? 32'(acc_addr[0]) : 32'hDEAD, 3);
    check("t2_ld_addr", acc_addr.size() > 1 ? 32'(acc_addr[1]) : 32'hDEAD, 3);
    check("t2_st_wdata", acc_wd.size() > 0 ? 32'(acc_wd[0]) : 32'hDEAD, 32'h1234);
    check("t2_st_we", acc_we.size() > 0 ? 32'(acc_we[0]) : 32'hDEAD, 1);
    check("t2_ld_we", acc_we.size() > 1 ? 32'(acc_we[1]) : 32'hDEAD, 0);
    check("t2_hold_err", hold_err, 0);
    check("t2_out_r3", qv(0), 32'h1234);
    check("t2_retired", retired, 11);

    // Six OUTs into a 4-deep FIFO with no consumer
    do_reset;
    for (int i = 0; i < 6; i++) begin
      prog.push_back(ri(OP_ADDI, 1, 1, 1));
      prog.push_back(ri(OP_OUT, 0, 1, 0));
    end
    prog.push_back(ri(OP_HLT, 0, 0, 0));
    load;
    test_normal = 1'b0;
    for (int i = 0; i < 60; i++) step;
    check("t3_stall_retired", retired, 9);
    check("t3_stall_done", 32'(done), 0);
    check("t3_stall_valid", 32'(out_valid), 1);
    check("t3_stall_head", 32'(out_data), 1);
    out_ready = 1'b1;
    run_until_done(200, c);
    step;
    step;
    check("t3_drained", outs.size(), 6);
    for (int i = 0; i < 6; i++) check("t3_order", qv(i), 32'(i + 1));
    check("t3_retired", retired, 12);

    // HLT holds until resume, then the following OUT runs
    do_reset;
    prog = '{ri(OP_ADDI, 1, 0, 7), ri(OP_HLT, 0, 0, 0), ri(OP_OUT, 0, 1, 0), ri(OP_HLT, 0, 0, 0)};
    load;
    out_ready = 1'b1;
    test_normal = 1'b0;
    run_until_done(40, c);
    check("t4_first_halt", c, 8);
    c = 0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (done) c++;
    end
    check("t4_done_held", c, 20);
    check("t4_halt_retired", retired, 1);
    check("t4_no_out", outs.size(), 0);
    resume = 1'b1;
    step;
    resume = 1'b0;
    check("t4_done_fell", 32'(done), 0);
    check("t4_resume_retired", retired, 2);
    run_until_done(40, c);
    check("t4_after_cycles", c, 7);
    check("t4_out_value", qv(0), 7);
    check("t4_final_retired", retired, 3);

    // test_normal during a withheld load aborts it without a register write
    do_reset;
    dmem[5] = 16'h0055;
    delay = 1000;
    prog = '{ri(OP_OUT, 0, 1, 0), ri(OP_LD, 1, 0, 5), ri(OP_OUT, 0, 1, 0), ri(OP_HLT, 0, 0, 0)};
    load;
    out_ready = 1'b1;
    test_normal = 1'b0;
    wait_req(50);
    step;
    step;
    test_normal = 1'b1;
    step;
    check("t5_req_dropped", 32'(dm_req), 0);
    check("t5_abort_retired", retired, 1);
    step;
    delay = 0;
    test_normal = 1'b0;
    run_until_done(100, c);
    step;
    check("t5_out_count", outs.size(), 3);
    check("t5_first_out", qv(0), 0);
    check("t5_rerun_r1_unwritten", qv(1), 0);
    check("t5_loaded", qv(2), 32'h55);
    check("t5_retired", retired, 4);

    // Asynchronous reset while a load waits
    do_reset;
    delay = 1000;
    prog = '{ri(OP_ADDI, 1, 0, 6), ri(OP_OUT, 0, 1, 0), ri(OP_LD, 3, 1, 6), ri(OP_HLT, 0, 0, 0)};
    load;
    test_normal = 1'b0;
    wait_req(50);
    check("t6_pre_addr", 32'(dm_addr), 12);
    check("t6_pre_wdata", 32'(dm_wdata), 6);
    check("t6_pre_valid", 32'(out_valid), 1);
    check("t6_pre_data", 32'(out_data), 6);
    check("t6_pre_retired", retired, 2);
    reset_n = 1'b0;
    #1;
    check("t6_dm_req", 32'(dm_req), 0);
    check("t6_dm_we", 32'(dm_we), 0);
    check("t6_dm_addr", 32'(dm_addr), 0);
    check("t6_dm_wdata", 32'(dm_wdata), 0);
    check("t6_out_valid", 32'(out_valid), 0);
    check("t6_out_data", 32'(out_data), 0);
    check("t6_done", 32'(done), 0);
    check("t6_retired", retired, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
